tick_timebase: RTL
==================

# tick_timebase

Parametrised multi-rate timebase. Successor to the fixed one-second timer chain: divides `clk` into single-cycle millisecond, second and (optionally) minute tick pulses, with a demo mode that shortens the millisecond period. Also produces a 50%-duty `oneSecondClk` and a wrapping elapsed-seconds count. Feeds every countdown/display block in the design.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency; real-mode ms divisor `MS_DIV = CLK_HZ/1000` (must be ≥2).
- `DEMO_DIV`, 50: ms-tick divisor in demo mode (≥2).
- `SEC_DIV`, 1000: ms ticks per second tick (even, ≥2).
- `MIN_DIV`, 60: second ticks per minute tick (≥2).
- `SEC_W`, 16: width of `elapsedSeconds`.
- `clk` in 1: the single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `enable` in 1: 1 = count, 0 = freeze all counters.
- `clear` in 1: synchronous restart of all counters without reset.
- `demoOrRealMode` in 1: 1 = demo (`DEMO_DIV`), 0 = real (`MS_DIV`).
- `msTick` out 1: one-cycle pulse per millisecond period.
- `secTick` out 1: one-cycle pulse per `SEC_DIV` ms ticks.
- `minTick` out 1: one-cycle pulse per `MIN_DIV` second ticks (0 when minute stage compiled out).
- `oneSecondClk` out 1: square wave, period = one second tick period.
- `elapsedSeconds` out `SEC_W`: count of second ticks since reset/clear.

## Operation
- Priority per edge: `reset` > `clear` > mode change > `enable`.
- `reset` or `clear`: prescaler, ms counter, sec counter, `elapsedSeconds` ← 0; all ticks ← 0; `oneSecondClk` ← 1.
- Stage 0 (prescaler `pre`, 0..DIV-1, DIV selected by registered mode): when enabled, `pre` increments; at `pre == DIV-1`, `pre` ← 0 and `msTick` ← 1.
- Stage 1 (`msCnt`, 0..SEC_DIV-1): advances on the same edge that sets `msTick`; wrap sets `secTick` ← 1 coincident with that `msTick`.
- Stage 2 (`secCnt`, 0..MIN_DIV-1): advances on the second-tick edge; wrap sets `minTick` coincident with `secTick` and `msTick`.
- `elapsedSeconds` increments on the edge that sets `secTick`; wraps 2^SEC_W-1 → 0 silently.
- `oneSecondClk` = 1 while `msCnt < SEC_DIV/2`, else 0 (registered).
- Mode change: `demoOrRealMode` is registered; on the edge where the registered value differs from the input, `pre` ← 0 and no tick fires; `msCnt`, `secCnt`, `elapsedSeconds` retained.
- `enable` = 0: all counters hold, all ticks 0, `oneSecondClk` holds.

## Timing
- All outputs registered; tick pulses exactly one cycle wide.
- With `enable` high from the first edge after `reset` deasserts, the first `msTick` is high in the cycle after the DIV-th edge; thereafter every DIV cycles.
- First `secTick` after DIV·SEC_DIV enabled cycles; first `minTick` after DIV·SEC_DIV·MIN_DIV.
- Disabled cycles stretch the period 1:1; no tick is lost or duplicated.
- A mode change takes effect on the next period, whose length is the new DIV counted from the restart edge.

## Configuration
- `TIMEBASE_MINUTE_EN` defined: stage 2 and `minTick` present.
- Not defined: no `secCnt`; `minTick` tied to 0; `MIN_DIV` ignored.

## Structure
- `timebase_pkg`: default divisor constants (`MS_PER_SEC`, `SEC_PER_MIN`), mode encoding constants `MODE_REAL`/`MODE_DEMO`, `clog2`-based width helper.
- Sub-module `tick_divider` (parameter `DIV`, inputs `clk`, `reset`, `clear`, `advance`, output `wrap` plus count), instantiated for stages 1 and 2; the stage 0 prescaler is inline because its divisor is mode-selected.

## Test plan
Bench parameters: `CLK_HZ`=10_000 (`MS_DIV`=10), `DEMO_DIV`=2, `SEC_DIV`=4, `MIN_DIV`=3.
- Real mode, `enable`=1 after reset -> `msTick` every 10 cycles, first in cycle 10; `secTick` first in cycle 40, coincident with the 4th `msTick`; `oneSecondClk` high for 20 cycles and low for 20.
- Demo mode -> `msTick` every 2 cycles, `secTick` every 8; with the macro, `minTick` every 24 cycles, coincident with `secTick`.
- `enable` low for 5 cycles mid-period -> that tick is delayed exactly 5 cycles; `elapsedSeconds` is unchanged during the pause.
- Toggle mode at `pre`=7 in real mode -> no tick on that edge; next `msTick` 2 cycles later; `msCnt` is preserved.
- `clear` and `enable` both high at `msCnt`=3 -> all counters 0, no `secTick`; `reset` mid-second -> all outputs 0, `oneSecondClk`=1.
- `SEC_W`=2 and run 5 seconds -> `elapsedSeconds` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/timebase_pkg.sv
// timebase_pkg: shared divisor defaults, mode encoding and counter width helper for the tick timebase.
package timebase_pkg;
  localparam int MS_PER_SEC = 1000;
  localparam int SEC_PER_MIN = 60;
  localparam logic MODE_REAL = 1'b0;
  localparam logic MODE_DEMO = 1'b1;
  function automatic int cntWidth(int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: modulo-DIV counter stepped by advance; wrap flags the advance that returns it to zero.
module tick_divider
  import timebase_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     advance,
  output logic                     wrap,
  output logic [cntWidth(DIV)-1:0] count
);
  localparam int W = cntWidth(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  assign wrap = advance && count == LAST;
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (advance) count <= wrap ? '0 : count + W'(1);
  end
endmodule

// File: rtl/tick_timebase.sv
// tick_timebase: ms/second/minute tick generator with demo-rate prescaler and elapsed-seconds count.
// Define TIMEBASE_MINUTE_EN to build the minute stage; otherwise minTick is tied low.
module tick_timebase
  import timebase_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DEMO_DIV = 50,
  parameter int SEC_DIV  = MS_PER_SEC,
  parameter int MIN_DIV  = SEC_PER_MIN,
  parameter int SEC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             demoOrRealMode,
  output logic             msTick,
  output logic             secTick,
  output logic             minTick,
  output logic             oneSecondClk,
  output logic [SEC_W-1:0] elapsedSeconds
);
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PRE_W = cntWidth(MS_DIV > DEMO_DIV ? MS_DIV : DEMO_DIV);
  localparam int MS_W = cntWidth(SEC_DIV);
  localparam logic [PRE_W-1:0] REAL_LAST = PRE_W'(MS_DIV - 1);
  localparam logic [PRE_W-1:0] DEMO_LAST = PRE_W'(DEMO_DIV - 1);
  localparam logic [MS_W-1:0] HALF_LAST = MS_W'(SEC_DIV / 2 - 1);

  logic [PRE_W-1:0] pre;
  logic [MS_W-1:0]  msCnt;
  logic             modeReg;
  logic             modeChange;
  logic             preLast;
  logic             msNext;
  logic             secNext;
  logic             minNext;

  // A mode switch restarts the prescaler and swallows whatever tick that edge would have produced.
  assign modeChange = demoOrRealMode != modeReg;
  assign preLast = pre == (modeReg == MODE_DEMO ? DEMO_LAST : REAL_LAST);
  assign msNext = enable && !modeChange && preLast;

  tick_divider #(.DIV(SEC_DIV)) msStage (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(msNext),
    .wrap   (secNext),
    .count  (msCnt)
  );

`ifdef TIMEBASE_MINUTE_EN
  logic [cntWidth(MIN_DIV)-1:0] secCnt;
  tick_divider #(.DIV(MIN_DIV)) secStage (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(secNext),
    .wrap   (minNext),
    .count  (secCnt)
  );
`else
  assign minNext = 1'b0;
`endif

  // oneSecondClk tracks the post-edge msCnt, so its edges line up with the secTick and half-second ms tick.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre            <= '0;
      modeReg        <= demoOrRealMode;
      msTick         <= 1'b0;
      secTick        <= 1'b0;
      minTick        <= 1'b0;
      oneSecondClk   <= 1'b1;
      elapsedSeconds <= '0;
    end else begin
      modeReg      <= demoOrRealMode;
      pre          <= (modeChange || (enable && preLast)) ? '0 : enable ? pre + PRE_W'(1) : pre;
      msTick       <= msNext;
      secTick      <= secNext;
      minTick      <= minNext;
      oneSecondClk <= secNext ? 1'b1 : (msNext && msCnt == HALF_LAST) ? 1'b0 : oneSecondClk;
      if (secNext) elapsedSeconds <= elapsedSeconds + SEC_W'(1);
    end
  end
endmodule
